wlan_deinterleaver_stream: RTL and testbench
============================================

Name: wlan_deinterleaver_stream

Overview:
- Streaming 802.11a/g receive-side block deinterleaver; replaces the single-shot, whole-vector deinterleaver with a parametrised, rate-adaptive, handshaked version.
- Accepts one soft coded bit per cycle in received order j; emits the same bits in deinterleaved order k.
- Covers all four modulations (Ncbps 48/96/192/288) and uses ping-pong buffering so that symbol n+1 can be written while symbol n is read.
- Sits between the demapper and the depuncturer/Viterbi.

Parameters:
- SOFT_W, 1, width of each soft bit (1 = hard decision).
- MAX_NCBPS, 288, bank depth in entries; must be ≥ 288 and divisible by 16.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_mode  input  2  modulation: 0 BPSK (Ncbps 48, s 1), 1 QPSK (96, 1), 2 16QAM (192, 2), 3 64QAM (288, 3).
- in_data  input  SOFT_W  soft bit j.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a bit.
- out_data  output  SOFT_W  soft bit k.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- out_last  output  1  marks k = Ncbps-1 of a symbol.
- out_mode  output  2  mode of the symbol being read.
- overflow  output  1  sticky flag: in_valid seen while in_ready = 0; cleared only by reset.

Behaviour:
- Reset (reset = 0, asynchronous): all outputs 0 except in_ready = 1. Both banks are empty, the write pointer selects bank 0, and all counters are 0. Bank RAM contents are don't-care. Reset asserted mid-symbol discards all partial and full symbols.
- Write FSM states: W_IDLE, W_FILL, W_WAIT.
  - W_IDLE: the first accepted beat latches in_mode into the bank's mode register, writes j = 0, and moves to W_FILL.
  - W_FILL: each accepted beat writes one bit. At j = Ncbps-1 the bank is marked full and the write side toggles to the other bank. The next state is W_IDLE if that bank is empty, else W_WAIT.
  - W_WAIT: in_ready = 0 until the target bank is freed by the reader.
- in_ready is 1 only when the target bank is empty, i.e. in W_IDLE or W_FILL.
- Changes to in_mode during W_FILL are ignored; the mode is fixed per symbol.
- A beat is accepted when in_valid & in_ready.
- Write address is k(j), per 802.11a 17.3.5.6, with Nrow = Ncbps/16:
  - c = floor(j/Nrow)
  - i = s*floor(j/s) + ((j + c) mod s)
  - k = 16*i - (Ncbps-1)*floor(i/Nrow)
  - Compute k from incremental counters: no dividers or multipliers in the data path. A row/col counter pair plus a mod-s counter is sufficient.
- Read FSM states: R_IDLE, R_DRAIN.
  - R_IDLE: waits for the read bank to be full. Then out_mode takes that bank's mode, and the block enters R_DRAIN.
  - R_DRAIN: reads addresses 0..Ncbps-1 sequentially.
- Read latency: one cycle registered RAM read. out_valid rises one cycle after entering R_DRAIN.
- Output hold: while out_valid & !out_ready, out_data, out_last and out_mode hold stable.
- Symbol end: on the transfer with out_last = 1, the bank is freed in the same cycle and the read side toggles banks. If the other bank is already full, the first bit of the next symbol follows with no more than 1 idle cycle.
- Simultaneous events: freeing a bank and the writer finishing the other bank in the same cycle must not lose either event. Writer-full and reader-free of the same bank cannot coincide.
- Throughput: sustained 1 bit/cycle in and out when out_ready = 1.
- End-to-end latency: first out_valid no earlier than Ncbps+1 cycles after the first accepted input bit.

Test Plan:
- BPSK, input 48 bits with only j = 3 set (SOFT_W = 1), out_ready = 1 -> one output symbol; only k = 1 is 1; out_last on the 48th beat; out_mode = 0.
- QPSK, only j = 6 set -> only k = 1 set. Then only j = 1 set -> only k = 16 set.
- 16QAM, only j = 12 set -> only k = 17 set. Only j = 1 set -> only k = 16 set.
- 64QAM, only j = 18 set -> only k = 17 set. Back-to-back 3 symbols with in_valid held high and out_ready = 1 -> all 864 bits correct; in_ready never drops for more than the ping-pong stall.
- Backpressure: out_ready = 0 after 10 output beats with the writer continuing -> second bank fills, in_ready = 0, out_data held. Driving in_valid then sets overflow = 1. Releasing out_ready -> stream resumes with no lost or duplicated bits.
- Reset pulse (reset = 0 for 1 cycle) mid-R_DRAIN of a 16QAM symbol -> outputs zero immediately, in_ready = 1. A following BPSK symbol is deinterleaved correctly with out_mode = 0.

Source files
------------

// File: rtl/wlan_deinterleaver_stream_if.sv
// Stream bundle for the 802.11a/g block deinterleaver.
//   in_mode/in_data/in_valid/in_ready : received-order soft bits from the demapper
//   out_data/out_valid/out_ready      : deinterleaved soft bits toward the depuncturer
//   out_last/out_mode                 : end-of-symbol marker and modulation of the symbol read
//   overflow                          : sticky "beat offered while not ready" flag
// slave is the deinterleaver side, master is the surrounding environment.
interface wlan_deinterleaver_stream_if #(
  parameter int SOFT_W = 1
) ();
  logic [1:0]        in_mode;
  logic [SOFT_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [SOFT_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [1:0]        out_mode;
  logic              overflow;

  modport slave (
    input  in_mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, out_mode, overflow
  );

  modport master (
    output in_mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_mode, overflow
  );
endinterface

// File: rtl/wlan_deinterleaver_stream.sv
// Streaming 802.11a/g receive block deinterleaver with ping-pong banks.
// Bits arrive one per cycle in received order j and are written to address
// k(j); the reader then drains the bank sequentially, so output order is k.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - stream bundle (slave side), see wlan_deinterleaver_stream_if
module wlan_deinterleaver_stream #(
  parameter int SOFT_W    = 1,
  parameter int MAX_NCBPS = 288
) (
  input logic clk,
  input logic reset,
  wlan_deinterleaver_stream_if.slave bus
);
  localparam int AW = $clog2(MAX_NCBPS);
  localparam int RW = AW - 4;  // row-index width; the low 4 address bits are the column

  typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  function automatic logic [AW-1:0] ncbps_m1(input logic [1:0] m);
    case (m)
      2'd0:    ncbps_m1 = AW'(47);
      2'd1:    ncbps_m1 = AW'(95);
      2'd2:    ncbps_m1 = AW'(191);
      default: ncbps_m1 = AW'(287);
    endcase
  endfunction

  function automatic logic [RW-1:0] nrow_m1(input logic [1:0] m);
    case (m)
      2'd0:    nrow_m1 = RW'(2);
      2'd1:    nrow_m1 = RW'(5);
      2'd2:    nrow_m1 = RW'(11);
      default: nrow_m1 = RW'(17);
    endcase
  endfunction

  function automatic logic [1:0] s_m1(input logic [1:0] m);
    case (m)
      2'd2:    s_m1 = 2'd1;
      2'd3:    s_m1 = 2'd2;
      default: s_m1 = 2'd0;
    endcase
  endfunction

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic              wbank_reg, rbank_reg;
  logic [1:0]        full_reg;
  logic [1:0]        full_set, full_clr, mode_load;
  logic [1:0]        bank_mode_reg [2];

  // Write-side address counters: row within column, column, j mod s,
  // row rounded down to a multiple of s, and column mod s.
  logic [RW-1:0]     row_reg, rowbase_reg;
  logic [3:0]        col_reg;
  logic [1:0]        q_reg, cm_reg;

  logic [AW-1:0]     raddr_reg;
  logic              rd_done_reg;
  logic              out_valid_reg, out_last_reg, overflow_reg;
  logic [1:0]        out_mode_reg;
  logic [SOFT_W-1:0] rd_data_reg;
  logic [SOFT_W-1:0] mem [2][MAX_NCBPS];

  logic [1:0]        cur_mode, cur_s_m1;
  logic [RW-1:0]     cur_nrow_m1;
  logic [2:0]        rot_sum;
  logic [1:0]        rot;
  logic [AW-1:0]     waddr, rd_last_addr;
  logic              in_ready, accept, w_last, rd_issue, rd_free, other_full;

  // ---------------- FSM state registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_reg <= W_IDLE;
      r_state_reg <= R_IDLE;
    end else begin
      w_state_reg <= w_state_next;
      r_state_reg <= r_state_next;
    end
  end

  // ---------------- FSM next-state logic ----------------
  always_comb begin
    w_state_next = w_state_reg;
    r_state_next = r_state_reg;
    // A free of the other bank in this very cycle counts as empty, so the
    // coincident writer-done / reader-free pair loses neither event.
    other_full = full_reg[~wbank_reg] & ~(rd_free & (rbank_reg != wbank_reg));
    case (w_state_reg)
      W_IDLE:  if (accept) w_state_next = W_FILL;
      W_FILL:  if (w_last) w_state_next = other_full ? W_WAIT : W_IDLE;
      default: if (!full_reg[wbank_reg]) w_state_next = W_IDLE;
    endcase
    case (r_state_reg)
      R_IDLE:  if (full_reg[rbank_reg]) r_state_next = R_DRAIN;
      default: if (rd_free) r_state_next = full_reg[~rbank_reg] ? R_DRAIN : R_IDLE;
    endcase
  end

  // ---------------- FSM outputs / address generation ----------------
  always_comb begin
    // The first beat of a symbol takes its mode straight from the input.
    cur_mode     = (w_state_reg == W_IDLE) ? bus.in_mode : bank_mode_reg[wbank_reg];
    cur_nrow_m1  = nrow_m1(cur_mode);
    cur_s_m1     = s_m1(cur_mode);
    in_ready     = (w_state_reg != W_WAIT);
    accept       = bus.in_valid & in_ready;
    w_last       = accept & (row_reg == cur_nrow_m1) & (col_reg == 4'd15);
    // k = 16*(rowbase + ((q + c mod s) mod s)) + c; Nrow is a multiple of s,
    // so floor(i/Nrow) is just the column and no divide is needed.
    rot_sum      = {1'b0, q_reg} + {1'b0, cm_reg};
    rot          = (rot_sum > {1'b0, cur_s_m1}) ? 2'(rot_sum - {1'b0, cur_s_m1} - 3'd1)
                                                : rot_sum[1:0];
    waddr        = {rowbase_reg + RW'(rot), col_reg};
    rd_last_addr = ncbps_m1(out_mode_reg);
    rd_free      = out_valid_reg & bus.out_ready & out_last_reg;
    rd_issue     = (r_state_reg == R_DRAIN) & ~rd_done_reg & (~out_valid_reg | bus.out_ready);
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign full_set[gi]  = w_last & (wbank_reg == 1'(gi));
    assign full_clr[gi]  = rd_free & (rbank_reg == 1'(gi));
    assign mode_load[gi] = accept & (w_state_reg == W_IDLE) & (wbank_reg == 1'(gi));
  end

  // ---------------- bank bookkeeping and write counters ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg      <= 2'b00;
      bank_mode_reg <= '{2'd0, 2'd0};
      wbank_reg     <= 1'b0;
      row_reg       <= '0;
      rowbase_reg   <= '0;
      col_reg       <= 4'd0;
      q_reg         <= 2'd0;
      cm_reg        <= 2'd0;
      overflow_reg  <= 1'b0;
    end else begin
      full_reg <= (full_reg | full_set) & ~full_clr;
      for (int b = 0; b < 2; b++)
        if (mode_load[b]) bank_mode_reg[b] <= bus.in_mode;
      if (bus.in_valid && !in_ready) overflow_reg <= 1'b1;
      if (accept) begin
        if (w_last) begin
          wbank_reg   <= ~wbank_reg;
          row_reg     <= '0;
          rowbase_reg <= '0;
          col_reg     <= 4'd0;
          q_reg       <= 2'd0;
          cm_reg      <= 2'd0;
        end else if (row_reg == cur_nrow_m1) begin
          row_reg     <= '0;
          rowbase_reg <= '0;
          q_reg       <= 2'd0;
          col_reg     <= col_reg + 4'd1;
          cm_reg      <= (cm_reg == cur_s_m1) ? 2'd0 : cm_reg + 2'd1;
        end else begin
          row_reg <= row_reg + RW'(1);
          if (q_reg == cur_s_m1) begin
            q_reg       <= 2'd0;
            rowbase_reg <= rowbase_reg + RW'(cur_s_m1 + 2'd1);
          end else begin
            q_reg <= q_reg + 2'd1;
          end
        end
      end
    end
  end

  // ---------------- read side ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rbank_reg     <= 1'b0;
      raddr_reg     <= '0;
      rd_done_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_mode_reg  <= 2'd0;
    end else begin
      if (r_state_reg == R_IDLE && r_state_next == R_DRAIN)
        out_mode_reg <= bank_mode_reg[rbank_reg];
      else if (rd_free && r_state_next == R_DRAIN)
        out_mode_reg <= bank_mode_reg[~rbank_reg];

      if (rd_free) begin
        rbank_reg   <= ~rbank_reg;
        raddr_reg   <= '0;
        rd_done_reg <= 1'b0;
      end else if (rd_issue) begin
        if (raddr_reg == rd_last_addr) rd_done_reg <= 1'b1;
        else                           raddr_reg   <= raddr_reg + AW'(1);
      end

      // Output stage only advances when empty or consumed, which holds it
      // stable under backpressure.
      if (rd_issue) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= (raddr_reg == rd_last_addr);
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  // ---------------- bank RAM, registered read ----------------
  always_ff @(posedge clk) begin
    if (accept)   mem[wbank_reg][waddr] <= bus.in_data;
    if (rd_issue) rd_data_reg <= mem[rbank_reg][raddr_reg];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_mode  = out_mode_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.out_data  = out_valid_reg ? rd_data_reg : '0;
endmodule

// File: tb/tb_wlan_deinterleaver_stream.sv
module tb_wlan_deinterleaver_stream;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wlan_deinterleaver_stream_if #(.SOFT_W(1)) bus ();
  wlan_deinterleaver_stream #(.SOFT_W(1), .MAX_NCBPS(288)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { logic d; logic last; logic [1:0] mode; } beat_t;
  typedef struct { int mode; int j; int k; } vec_t;

  beat_t outq[$];
  int errors = 0, checks = 0;
  int cyc = 0, t_in = -1, t_out = -1;
  int stall_run = 0, stall_max = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready)
      outq.push_back('{bus.out_data[0], bus.out_last, bus.out_mode});
    if (reset && bus.out_valid && t_out < 0) t_out = cyc;
    if (!bus.in_ready) stall_run = stall_run + 1; else stall_run = 0;
    if (stall_run > stall_max) stall_max = stall_run;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int nbits(input int mode);
    case (mode)
      0: return 48;
      1: return 96;
      2: return 192;
      default: return 288;
    endcase
  endfunction

  // Reference mapping written straight from the standard's formula.
  function automatic int kmap(input int mode, input int j);
    int n, s, nrow, c, i;
    n = nbits(mode);
    s = (mode == 3) ? 3 : (mode == 2) ? 2 : 1;
    nrow = n / 16;
    c = j / nrow;
    i = s * (j / s) + ((j + c) % s);
    return 16 * i - (n - 1) * (i / nrow);
  endfunction

  task automatic send_sym(input int mode, input logic [287:0] bits, input int n);
    int g;
    for (int j = 0; j < n; j++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = 2'(mode);
      bus.in_data  = bits[j];
      g = 0;
      @(negedge clk);
      while (!bus.in_ready && g < 3000) begin
        @(negedge clk);
        g++;
      end
      if (!bus.in_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck at 0 at j=%0d, expected 1", j);
        break;
      end
      @(posedge clk);
      #1;
      if (j == 0 && t_in < 0) t_in = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int g;
    g = 0;
    while (outq.size() < n && g < 5000) begin
      @(posedge clk);
      g++;
    end
    #1;
  endtask

  task automatic run_vec(input string name, input int mode, input int jset, input int expk);
    logic [287:0] bits;
    beat_t b;
    int n, ones, pos, lastpos, lastcnt, cnt;
    logic [1:0] m0;
    n = nbits(mode);
    bits = '0;
    bits[jset] = 1'b1;
    outq.delete();
    t_in = -1;
    t_out = -1;
    send_sym(mode, bits, n);
    wait_out(n);
    cnt = outq.size();
    ones = 0; pos = -1; lastpos = -1; lastcnt = 0;
    m0 = ~2'(mode);
    for (int m = 0; m < n && outq.size() > 0; m++) begin
      b = outq.pop_front();
      if (m == 0) m0 = b.mode;
      if (b.d) begin ones++; pos = m; end
      if (b.last) begin lastcnt++; lastpos = m; end
    end
    $display("vec %s: mode=%0d j=%0d -> k=%0d (expect %0d) last@%0d", name, mode, jset, pos, expk, lastpos);
    chk({name, "_count"}, cnt, n);
    chk({name, "_ones"}, ones, 1);
    chk({name, "_k"}, pos, expk);
    chk({name, "_lastpos"}, lastpos, n - 1);
    chk({name, "_lastcnt"}, lastcnt, 1);
    chk({name, "_mode"}, int'(m0), mode);
    chk({name, "_latency_ok"}, int'((t_out - t_in) >= n + 1), 1);
  endtask

  vec_t vecs[9];
  logic [287:0] sb [3];
  logic expv [3][288];
  int bad, lastbad, modebad, cnt, stall_snap, heldbad;
  logic d_held;
  beat_t b;

  initial begin
    vecs[0] = '{0, 3, 1};
    vecs[1] = '{0, 47, 47};
    vecs[2] = '{1, 6, 1};
    vecs[3] = '{1, 1, 16};
    vecs[4] = '{2, 12, 17};
    vecs[5] = '{2, 1, 16};
    vecs[6] = '{3, 18, 17};
    vecs[7] = '{3, 1, 16};
    vecs[8] = '{3, 287, 287};

    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_mode = 2'd0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_mode", int'(bus.out_mode), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 9; v++)
      run_vec($sformatf("v%0d", v), vecs[v].mode, vecs[v].j, vecs[v].k);
    chk("no_overflow_after_vectors", int'(bus.overflow), 0);

    // Back-to-back 64QAM symbols with in_valid held high.
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 288; j++) sb[s][j] = 1'($urandom_range(0, 1));
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 288; j++) expv[s][kmap(3, j)] = sb[s][j];
    outq.delete();
    stall_max = 0;
    for (int s = 0; s < 3; s++) send_sym(3, sb[s], 288);
    stall_snap = stall_max;
    wait_out(864);
    cnt = outq.size();
    bad = 0; lastbad = 0; modebad = 0;
    for (int m = 0; m < 864 && outq.size() > 0; m++) begin
      b = outq.pop_front();
      if (b.d !== expv[m / 288][m % 288]) bad++;
      if (b.last !== ((m % 288) == 287)) lastbad++;
      if (b.mode !== 2'd3) modebad++;
    end
    $display("b2b: beats=%0d bad=%0d lastbad=%0d modebad=%0d max_stall=%0d", cnt, bad, lastbad, modebad, stall_snap);
    chk("b2b_count", cnt, 864);
    chk("b2b_data", bad, 0);
    chk("b2b_last", lastbad, 0);
    chk("b2b_mode", modebad, 0);
    chk("b2b_stall_le3", int'(stall_snap <= 3), 1);

    // Backpressure with the writer running ahead.
    @(posedge clk); #2; reset = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #2; reset = 1'b1;
    outq.delete();
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 288; j++) sb[s][j] = (j < 48) ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int s = 0; s < 3; s++)
      for (int j = 0; j < 48; j++) expv[s][kmap(0, j)] = sb[s][j];
    fork
      begin
        for (int s = 0; s < 3; s++) send_sym(0, sb[s], 48);
      end
      begin
        cnt = 0;
        while (outq.size() < 10 && cnt < 2000) begin
          @(posedge clk);
          cnt++;
        end
        #1;
        bus.out_ready = 1'b0;
        repeat (150) @(posedge clk);
        @(negedge clk);
        $display("bp: in_ready=%0d overflow=%0d out_valid=%0d out_data=%0d", bus.in_ready, bus.overflow, bus.out_valid, bus.out_data);
        chk("bp_beats_before_stall", outq.size(), 10);
        chk("bp_in_ready", int'(bus.in_ready), 0);
        chk("bp_overflow", int'(bus.overflow), 1);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk("bp_out_data", int'(bus.out_data), int'(expv[0][10]));
        chk("bp_out_last", int'(bus.out_last), 0);
        d_held = bus.out_data[0];
        heldbad = 0;
        repeat (5) begin
          @(negedge clk);
          if (bus.out_data[0] !== d_held || !bus.out_valid) heldbad++;
        end
        chk("bp_hold", heldbad, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_out(144);
    cnt = outq.size();
    bad = 0; lastbad = 0;
    for (int m = 0; m < 144 && outq.size() > 0; m++) begin
      b = outq.pop_front();
      if (b.d !== expv[m / 48][m % 48]) bad++;
      if (b.last !== ((m % 48) == 47)) lastbad++;
    end
    $display("bp resume: beats=%0d bad=%0d lastbad=%0d", cnt, bad, lastbad);
    chk("bp_count", cnt, 144);
    chk("bp_data", bad, 0);
    chk("bp_last", lastbad, 0);
    chk("bp_overflow_sticky", int'(bus.overflow), 1);

    // Reset pulse in the middle of draining a 16QAM symbol.
    outq.delete();
    sb[0] = '0;
    sb[0][12] = 1'b1;
    send_sym(2, sb[0], 192);
    wait_out(20);
    chk("mid_mode_before_reset", int'(bus.out_mode), 2);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    $display("mid reset: out_valid=%0d out_mode=%0d in_ready=%0d", bus.out_valid, bus.out_mode, bus.in_ready);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_mode", int'(bus.out_mode), 0);
    chk("mid_rst_out_last", int'(bus.out_last), 0);
    chk("mid_rst_out_data", int'(bus.out_data), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_overflow", int'(bus.overflow), 0);
    @(posedge clk); #2;
    reset = 1'b1;
    outq.delete();
    run_vec("after_rst_bpsk", 0, 10, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
